// File: rtl/gate_eval_responder_if.sv
// gate_eval_responder_if
//   Bundles the request and response handshakes of the gate-evaluation
//   responder.
//
//   Request side:  in_valid, in_ready, in_c, in_b, in_tag
//   Response side: out_valid, out_ready, out_a, out_b, out_c, out_y, out_tag
//
//   Modports:
//     slave  - the responder; it consumes requests and produces responses
//     master - the sequencer or bench; it issues requests and consumes responses
//
//   Parameter TAG_W sets the width of the tag that travels with each
//   request/response pair.
interface gate_eval_responder_if #(
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic             in_c;
    logic             in_b;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic             out_a;
    logic             out_b;
    logic             out_c;
    logic             out_y;
    logic [TAG_W-1:0] out_tag;

    modport slave (
        input  in_valid, in_c, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_a, out_b, out_c, out_y, out_tag
    );

    modport master (
        output in_valid, in_c, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_c, out_y, out_tag
    );
endinterface

// File: rtl/gate_eval_responder.sv
// gate_eval_responder
//   Two-stage pipelined responder for the (c, b) gate-evaluation
//   interface. It accepts request vectors {c, b} and a tag. It returns
//   {a, b, c, y} with the same tag, two clock edges after the request is
//   accepted. When the consumer is always ready it delivers one response
//   per cycle. Responses come back strictly in request order.
//
//   Ports:
//     clk       - single clock; all state updates on the rising edge
//     reset     - asynchronous, active-low; 0 clears all state immediately
//     bus       - gate_eval_responder_if.slave (request/response handshakes)
//     txn_count - retired-response count, wraps modulo 2^CNT_W
//                 (only exists when GATE_EVAL_TXN_CNT_EN is defined)
//
//   Parameters:
//     TAG_W - tag width; it must match the TAG_W of the connected interface
//     CNT_W - width of the optional transaction counter
//
//   Optional feature macro: GATE_EVAL_TXN_CNT_EN
module gate_eval_responder #(
    parameter int TAG_W = 4,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    gate_eval_responder_if.slave    bus
`ifdef GATE_EVAL_TXN_CNT_EN
    ,
    output logic [CNT_W-1:0]        txn_count
`endif
);

    // Stage 1: registered operands, tag, and the first gate term a.
    logic             s1_valid;
    logic             s1_c;
    logic             s1_b;
    logic             s1_a;
    logic [TAG_W-1:0] s1_tag;

    // Stage 2: the fully evaluated response. It drives the outputs directly.
    logic             s2_valid;
    logic             s2_a;
    logic             s2_b;
    logic             s2_c;
    logic             s2_y;
    logic [TAG_W-1:0] s2_tag;

    logic adv1;
    logic adv2;
    logic accept;
    logic load2;

    // A stage may advance when it is empty or when the stage after it is
    // moving. The ready signal therefore ripples back one level from
    // out_ready to in_ready.
    assign adv2   = ~s2_valid | bus.out_ready;
    assign adv1   = ~s1_valid | adv2;
    assign accept = bus.in_valid & adv1;
    assign load2  = adv2 & s1_valid;

    assign bus.in_ready = adv1;

    // Stage 1 data loads only on a real accept. Idle inputs (possibly X)
    // never reach the data registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_c     <= 1'b0;
            s1_b     <= 1'b0;
            s1_a     <= 1'b0;
            s1_tag   <= '0;
        end else begin
            if (adv1) begin
                s1_valid <= bus.in_valid;
            end
            if (accept) begin
                s1_c   <= bus.in_c;
                s1_b   <= bus.in_b;
                s1_a   <= ~(bus.in_c | bus.in_b);
                s1_tag <= bus.in_tag;
            end
        end
    end

    // Stage 2 uses the reduced forms of the remaining gate networks. While
    // stalled it holds its contents, so the response stays stable until it
    // is taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_valid <= 1'b0;
            s2_a     <= 1'b0;
            s2_b     <= 1'b0;
            s2_c     <= 1'b0;
            s2_y     <= 1'b0;
            s2_tag   <= '0;
        end else begin
            if (adv2) begin
                s2_valid <= s1_valid;
            end
            if (load2) begin
                s2_a   <= s1_a;
                s2_b   <= s1_c | s1_b;
                s2_c   <= s1_a ^ s1_b;
                s2_y   <= s1_b | ~s1_c;
                s2_tag <= s1_tag;
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.out_a     = s2_a;
    assign bus.out_b     = s2_b;
    assign bus.out_c     = s2_c;
    assign bus.out_y     = s2_y;
    assign bus.out_tag   = s2_tag;

`ifdef GATE_EVAL_TXN_CNT_EN
    // Counts responses as they retire. The count wraps naturally at
    // 2^CNT_W.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            txn_count <= '0;
        end else if (s2_valid && bus.out_ready) begin
            txn_count <= txn_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_gate_eval_responder.sv
// tb_gate_eval_responder
//   Directed testbench for gate_eval_responder. It drives the request and
//   response handshakes through the interface. Expected results come from
//   a hand-computed truth table: {c,b} 00->1011, 01->0111, 10->0100,
//   11->0111. Inputs change and outputs are sampled 1 ns after each rising
//   edge.
//
//   Optional feature macro: GATE_EVAL_TXN_CNT_EN
module tb_gate_eval_responder;

    localparam int TAG_W = 4;
    localparam int CNT_W = 8;

    logic clk;
    logic reset;

    int checks;
    int errors;

    logic [3:0] exp_tab [4];

    gate_eval_responder_if #(.TAG_W(TAG_W)) bus ();

`ifdef GATE_EVAL_TXN_CNT_EN
    logic [CNT_W-1:0] txn_count;
`endif

    gate_eval_responder #(
        .TAG_W(TAG_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef GATE_EVAL_TXN_CNT_EN
        ,
        .txn_count (txn_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packs the four evaluated response bits into one vector.
    function automatic logic [3:0] resp();
        return {bus.out_a, bus.out_b, bus.out_c, bus.out_y};
    endfunction

    // Drives one request onto the request handshake.
    task automatic applyStimulus(input logic valid, input logic [1:0] cb,
                                 input logic [TAG_W-1:0] tag);
        bus.in_valid = valid;
        bus.in_c     = cb[1];
        bus.in_b     = cb[0];
        bus.in_tag   = tag;
    endtask

    // One immediate-assertion comparison. A failure is counted and reported.
    task automatic checkOutput(input string name, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", name, observed, expected);
        end
    endtask

    // Advances to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        exp_tab[0] = 4'b1011;
        exp_tab[1] = 4'b0111;
        exp_tab[2] = 4'b0100;
        exp_tab[3] = 4'b0111;

        reset         = 1'b0;
        bus.out_ready = 1'b0;
        applyStimulus(1'b0, 2'b00, '0);

        // 1. Reset, then idle
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        reset = 1'b1;
        #1;
        checkOutput("idle_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("idle_resp", 32'(resp()), 32'd0);
        checkOutput("idle_tag", 32'(bus.out_tag), 32'd0);
        checkOutput("idle_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef GATE_EVAL_TXN_CNT_EN
        checkOutput("idle_txn_count", 32'(txn_count), 32'd0);
`endif

        // 2. Stream all four vectors back-to-back with out_ready high
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 2'(i), 4'(i));
            #1;
            checkOutput("stream_in_ready", 32'(bus.in_ready), 32'd1);
            tick();
            if (i == 0) begin
                checkOutput("stream_first_latency", 32'(bus.out_valid), 32'd0);
            end else begin
                checkOutput("stream_valid", 32'(bus.out_valid), 32'd1);
                checkOutput("stream_resp", 32'(resp()), 32'(exp_tab[i-1]));
                checkOutput("stream_tag", 32'(bus.out_tag), 32'(i-1));
            end
        end
        applyStimulus(1'b0, 2'b00, '0);
        tick();
        checkOutput("stream_last_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("stream_last_resp", 32'(resp()), 32'(exp_tab[3]));
        checkOutput("stream_last_tag", 32'(bus.out_tag), 32'd3);
        tick();
        checkOutput("stream_drained", 32'(bus.out_valid), 32'd0);

        // 3. Backpressure: three requests while out_ready is low
        bus.out_ready = 1'b0;
        applyStimulus(1'b1, 2'b00, 4'd5);
        #1;
        checkOutput("bp_ready_t5", 32'(bus.in_ready), 32'd1);
        tick();
        applyStimulus(1'b1, 2'b01, 4'd6);
        #1;
        checkOutput("bp_ready_t6", 32'(bus.in_ready), 32'd1);
        tick();
        applyStimulus(1'b1, 2'b10, 4'd7);
        #1;
        checkOutput("bp_full_in_ready", 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("bp_hold_tag", 32'(bus.out_tag), 32'd5);
            checkOutput("bp_hold_resp", 32'(resp()), 32'(exp_tab[0]));
            checkOutput("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        #1;
        checkOutput("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        applyStimulus(1'b0, 2'b00, '0);
        checkOutput("bp_order_tag6", 32'(bus.out_tag), 32'd6);
        checkOutput("bp_order_resp6", 32'(resp()), 32'(exp_tab[1]));
        tick();
        checkOutput("bp_order_valid7", 32'(bus.out_valid), 32'd1);
        checkOutput("bp_order_tag7", 32'(bus.out_tag), 32'd7);
        checkOutput("bp_order_resp7", 32'(resp()), 32'(exp_tab[2]));
        tick();
        checkOutput("bp_drained", 32'(bus.out_valid), 32'd0);

        // 4. Retire and accept in the same cycle
        applyStimulus(1'b1, 2'b11, 4'd8);
        tick();
        checkOutput("sim_t8_in_s1", 32'(bus.out_valid), 32'd0);
        applyStimulus(1'b1, 2'b00, 4'd9);
        tick();
        checkOutput("sim_t8_out", 32'(bus.out_tag), 32'd8);
        checkOutput("sim_t8_resp", 32'(resp()), 32'(exp_tab[3]));
        applyStimulus(1'b1, 2'b01, 4'd10);
        #1;
        checkOutput("sim_both_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        applyStimulus(1'b0, 2'b00, '0);
        checkOutput("sim_t9_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("sim_t9_tag", 32'(bus.out_tag), 32'd9);
        checkOutput("sim_t9_resp", 32'(resp()), 32'(exp_tab[0]));
        tick();
        checkOutput("sim_t10_tag", 32'(bus.out_tag), 32'd10);
        checkOutput("sim_t10_resp", 32'(resp()), 32'(exp_tab[1]));
        tick();
        checkOutput("sim_drained", 32'(bus.out_valid), 32'd0);

        // 5. Reset pulse while both stages are full and stalled
        bus.out_ready = 1'b0;
        applyStimulus(1'b1, 2'b10, 4'd11);
        tick();
        applyStimulus(1'b1, 2'b11, 4'd12);
        tick();
        applyStimulus(1'b0, 2'b00, '0);
        checkOutput("mid_full_tag", 32'(bus.out_tag), 32'd11);
        checkOutput("mid_full_in_ready", 32'(bus.in_ready), 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("mid_async_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("mid_async_tag", 32'(bus.out_tag), 32'd0);
        checkOutput("mid_async_resp", 32'(resp()), 32'd0);
        tick();
        reset = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        checkOutput("mid_release_in_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("mid_no_stale", 32'(bus.out_valid), 32'd0);
        end

`ifdef GATE_EVAL_TXN_CNT_EN
        // 6. Counter wrap after 257 retirements
        reset = 1'b0;
        #1;
        checkOutput("cnt_reset", 32'(txn_count), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 257; i++) begin
            applyStimulus(1'b1, 2'(i), 4'(i));
            tick();
        end
        applyStimulus(1'b0, 2'b00, '0);
        repeat (3) tick();
        checkOutput("cnt_wrap", 32'(txn_count), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
